// File: rtl/multi_issue_pc_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : multi_issue_pc_gen_if
//  Description : Redirect / halt / fetch-bundle bundle between the PC generator
//                and its producers (branch resolution) and consumer (fetch).
//  Revision    : 1.0 - initial release
// ============================================================================
interface multi_issue_pc_gen_if #(
    parameter int WIDTH   = 32,
    parameter int FETCH_W = 2,
    parameter int REDIR_N = 4,
    parameter int CNT_W   = 16
);
    logic [REDIR_N-1:0]       redir_valid;
    logic [REDIR_N*WIDTH-1:0] redir_target;
    logic                     halt;
    logic                     fetch_ready;
    logic                     fetch_valid;
    logic [FETCH_W*WIDTH-1:0] fetch_pc;
    logic [FETCH_W-1:0]       fetch_mask;
    logic                     misalign_err;
    logic [CNT_W-1:0]         redirect_cnt;

    modport master (
        output redir_valid, redir_target, halt, fetch_ready,
        input  fetch_valid, fetch_pc, fetch_mask, misalign_err, redirect_cnt
    );

    modport slave (
        input  redir_valid, redir_target, halt, fetch_ready,
        output fetch_valid, fetch_pc, fetch_mask, misalign_err, redirect_cnt
    );
endinterface
`default_nettype wire

// File: rtl/multi_issue_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : multi_issue_pc_gen
//  Description : Registered fetch-PC generator with prioritised redirects,
//                FETCH_W-wide lane-masked bundles, halt and redirect counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_issue_pc_gen #(
    parameter int               WIDTH     = 32,
    parameter int               FETCH_W   = 2,
    parameter int               REDIR_N   = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               CNT_W     = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    multi_issue_pc_gen_if.slave bus
);

    localparam int c_LOG_F = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_pc;
    logic               r_fetch_valid;
    logic               r_misalign;
    logic [CNT_W-1:0]   r_cnt;

    logic [c_LOG_F-1:0] w_off;
    logic [WIDTH-1:0]   w_step;
    logic [WIDTH-1:0]   w_redir_tgt;
    logic               w_redir_any;
    logic               w_apply;

    // Lane offset of pc inside its FETCH_W*4-byte block
    generate
        if (FETCH_W > 1) begin : g_off_multi
            assign w_off = r_pc[2 +: c_LOG_F];
        end else begin : g_off_single
            assign w_off = '0;
        end
    endgenerate

    assign w_step = WIDTH'((FETCH_W - int'(w_off)) * 4);

    // Lowest index wins: scan from the top so the last hit is the winner
    always_comb begin
        w_redir_tgt = '0;
        for (int k = REDIR_N - 1; k >= 0; k--) begin
            if (bus.redir_valid[k]) begin
                w_redir_tgt = bus.redir_target[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_redir_any = |bus.redir_valid;
    assign w_apply     = w_redir_any && (r_state != ST_BOOT);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_VEC;
            r_fetch_valid <= 1'b0;
            r_misalign    <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_misalign <= 1'b0;

            // A redirect always beats the sequential advance
            if (w_apply) begin
                r_pc       <= {w_redir_tgt[WIDTH-1:2], 2'b00};
                r_misalign <= |w_redir_tgt[1:0];
                if (~&r_cnt) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (r_state == ST_RUN && bus.fetch_ready) begin
                r_pc <= r_pc + w_step;
            end

            case (r_state)
                ST_BOOT: begin
                    r_state       <= bus.halt ? ST_HALTED : ST_RUN;
                    r_fetch_valid <= ~bus.halt;
                end
                ST_RUN: begin
                    if (bus.halt && !w_redir_any) begin
                        r_state       <= ST_HALTED;
                        r_fetch_valid <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    if (!bus.halt) begin
                        r_state       <= ST_RUN;
                        r_fetch_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= ST_BOOT;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar i = 0; i < FETCH_W; i++) begin : g_lane
            assign bus.fetch_pc[i*WIDTH +: WIDTH] = r_pc + WIDTH'(4 * i);
            assign bus.fetch_mask[i]              = (int'(w_off) + i) < FETCH_W;
        end
    endgenerate

    assign bus.fetch_valid  = r_fetch_valid;
    assign bus.misalign_err = r_misalign;
    assign bus.redirect_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multi_issue_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_issue_pc_gen
//  Description : Directed plus randomized self-checking bench for the fetch-PC
//                generator against a block-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_issue_pc_gen;

    localparam int W    = 32;
    localparam int F    = 2;
    localparam int R    = 4;
    localparam int C    = 16;
    localparam int BLK  = 4 * F;
    localparam int CMAX = (1 << C) - 1;

    logic CLK    = 1'b0;
    logic RST_N  = 1'b0;
    logic RST2_N = 1'b0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    always #5 CLK = ~CLK;

    multi_issue_pc_gen_if #(.WIDTH(W), .FETCH_W(F), .REDIR_N(R), .CNT_W(C)) bus ();
    multi_issue_pc_gen_if #(.WIDTH(W), .FETCH_W(F), .REDIR_N(R), .CNT_W(2)) bus2 ();

    multi_issue_pc_gen #(.WIDTH(W), .FETCH_W(F), .REDIR_N(R), .RESET_VEC(32'h0), .CNT_W(C))
        dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

    multi_issue_pc_gen #(.WIDTH(W), .FETCH_W(F), .REDIR_N(R), .RESET_VEC(32'h0), .CNT_W(2))
        dut2 (.CLK(CLK), .RST_N(RST2_N), .bus(bus2));

    // Reference model: architectural pc plus "booting"/"halted" flags
    logic [W-1:0] m_pc;
    bit           m_boot;
    bit           m_halted;
    bit           m_mis;
    int           m_cnt;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [F*W-1:0] e_pc;
        logic [F-1:0]   e_mask;
        for (int i = 0; i < F; i++) begin
            e_pc[i*W +: W] = m_pc + W'(4 * i);
            e_mask[i] = ((64'(m_pc) + 64'(4 * i)) / 64'(BLK)) == (64'(m_pc) / 64'(BLK));
        end
        chk({tag, ".valid"}, bus.fetch_valid, !(m_boot || m_halted));
        chk({tag, ".pc"},    bus.fetch_pc, e_pc);
        chk({tag, ".mask"},  bus.fetch_mask, e_mask);
        chk({tag, ".mis"},   bus.misalign_err, m_mis);
        chk({tag, ".cnt"},   bus.redirect_cnt, m_cnt);
    endtask

    task automatic step(input string tag);
        logic [W-1:0] tgt;
        bit           any;
        any = 0;
        tgt = '0;
        for (int k = 0; k < R; k++) begin
            if (!any && bus.redir_valid[k]) begin
                any = 1;
                tgt = bus.redir_target[k*W +: W];
            end
        end
        if (m_boot) begin
            m_boot   = 0;
            m_halted = bus.halt;
            m_mis    = 0;
        end else begin
            m_mis = 0;
            if (any) begin
                m_pc  = tgt & ~32'h3;
                m_mis = (tgt % 4) != 0;
                if (m_cnt < CMAX) m_cnt++;
                if (m_halted) m_halted = bus.halt;
            end else if (!m_halted) begin
                if (bus.fetch_ready)
                    m_pc = W'(((64'(m_pc) / 64'(BLK)) + 64'd1) * 64'(BLK));
                if (bus.halt) m_halted = 1;
            end else begin
                m_halted = bus.halt;
            end
        end
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        RST_N    = 1'b0;
        m_pc     = '0;
        m_boot   = 1;
        m_halted = 0;
        m_mis    = 0;
        m_cnt    = 0;
        #1;
        check_all({tag, ".in"});
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        #1;
        check_all({tag, ".rel"});
    endtask

    task automatic clear_in();
        bus.redir_valid = '0;
        bus.halt        = 1'b0;
        bus.fetch_ready = 1'b0;
    endtask

    task automatic redir(input int k, input logic [W-1:0] t);
        bus.redir_valid[k]          = 1'b1;
        bus.redir_target[k*W +: W]  = t;
    endtask

    function automatic logic [W-1:0] rand_target();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 | W'($urandom_range(0, 15));
        return W'($urandom);
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e2;
        bus.redir_target  = '0;
        bus2.redir_valid  = '0;
        bus2.redir_target = '0;
        bus2.halt         = 1'b0;
        bus2.fetch_ready  = 1'b0;
        clear_in();

        do_reset("rst0");
        RST2_N = 1'b1;

        // Boot cycle then two accepts
        bus.fetch_ready = 1'b1;
        step("boot");
        chk("t1.pc0", bus.fetch_pc, 64'h0000_0004_0000_0000);
        chk("t1.mask0", bus.fetch_mask, 2'b11);
        step("adv1");
        step("adv2");
        chk("t1.pc10", bus.fetch_pc[W-1:0], 32'h10);

        // Redirect into the upper lane of a block
        clear_in();
        redir(0, 32'h104);
        step("r104");
        chk("t2.pc104", bus.fetch_pc, 64'h0000_0108_0000_0104);
        chk("t2.mask01", bus.fetch_mask, 2'b01);
        clear_in();
        bus.fetch_ready = 1'b1;
        step("acc104");
        chk("t2.pc108", bus.fetch_pc[W-1:0], 32'h108);
        chk("t2.cnt1", bus.redirect_cnt, 16'd1);

        // Stall holds, redirect without ready still applies
        clear_in();
        redir(1, 32'h20);
        step("r20");
        clear_in();
        repeat (3) step("stall");
        chk("t3.hold20", bus.fetch_pc[W-1:0], 32'h20);
        redir(3, 32'h40);
        step("r40");
        chk("t3.pc40", bus.fetch_pc[W-1:0], 32'h40);

        // Priority and misalignment
        clear_in();
        bus.redir_valid = 4'b0101;
        bus.redir_target[0*W +: W] = 32'h200;
        bus.redir_target[2*W +: W] = 32'h300;
        step("prio");
        chk("t4.pc200", bus.fetch_pc[W-1:0], 32'h200);
        chk("t4.cnt4", bus.redirect_cnt, 16'd4);
        clear_in();
        redir(0, 32'h202);
        bus.redir_target[2*W +: W] = 32'h301;
        step("mis");
        chk("t4.mis1", bus.misalign_err, 1'b1);
        chk("t4.pc200b", bus.fetch_pc[W-1:0], 32'h200);
        clear_in();
        step("mis_clr");

        // Halt with accept, redirect while halted, resume
        bus.fetch_ready = 1'b1;
        bus.halt        = 1'b1;
        step("halt_acc");
        chk("t5.pc208", bus.fetch_pc[W-1:0], 32'h208);
        chk("t5.valid0", bus.fetch_valid, 1'b0);
        bus.fetch_ready = 1'b0;
        redir(2, 32'h80);
        step("halt_r80");
        chk("t5.pc80", bus.fetch_pc[W-1:0], 32'h80);
        clear_in();
        step("resume");
        chk("t5.valid1", bus.fetch_valid, 1'b1);

        // Asynchronous reset mid-stall
        redir(0, 32'h1C);
        step("r1c");
        clear_in();
        step("stall1c");
        #3;
        do_reset("midrst");
        chk("t6.cnt0", bus.redirect_cnt, 16'd0);

        // Randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 400; n++) begin
            bus.redir_valid = ($urandom_range(0, 3) == 0) ? R'($urandom) : '0;
            for (int k = 0; k < R; k++) bus.redir_target[k*W +: W] = rand_target();
            bus.halt        = ($urandom_range(0, 7) == 0);
            bus.fetch_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) begin
                #3;
                do_reset("rnd_rst");
            end else begin
                step("rnd");
            end
        end

        // Narrow counter saturates at 3
        e2 = 0;
        for (int n = 0; n < 5; n++) begin
            bus2.redir_valid = 4'b0001;
            bus2.redir_target[0 +: W] = W'(32'h100 + 16 * n);
            @(posedge CLK);
            #1;
            e2 = (e2 < 3) ? e2 + 1 : 3;
            chk("t6.sat", bus2.redirect_cnt, e2);
        end
        bus2.redir_valid = '0;
        chk("t6.sat3", bus2.redirect_cnt, 2'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_issue_pc_gen.md
Name: multi_issue_pc_gen

Overview:
Parametrised fetch-PC generator for the superscalar OTTER front end. It replaces the combinational PC select mux with a registered PC, a configurable number of prioritised redirect sources and a FETCH_W-wide fetch bundle with a lane-valid mask. It adds a valid/ready handshake to the fetch stage, a halt state, misaligned-target detection and a redirect performance counter. It sits between the branch/jump resolution logic (redirect producers) and the instruction memory/fetch queue (bundle consumer).

Parameters:
WIDTH, 32, address width in bits
FETCH_W, 2, instructions per fetch bundle; power of 2, range 1..8
REDIR_N, 4, number of redirect sources; index 0 has the highest priority
RESET_VEC, 32'h0000_0000, PC loaded on reset; must be FETCH_W*4-aligned
CNT_W, 16, redirect counter width

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  reset
redir_valid  in  REDIR_N  per-source redirect request, single-cycle
redir_target  in  REDIR_N*WIDTH  target for source k at [k*WIDTH +: WIDTH]
halt  in  1  level; stop fetching while high
fetch_ready  in  1  consumer accepts the bundle this cycle
fetch_valid  out  1  bundle valid
fetch_pc  out  FETCH_W*WIDTH  lane i PC at [i*WIDTH +: WIDTH]
fetch_mask  out  FETCH_W  lane-valid bits
misalign_err  out  1  one-cycle pulse: the applied redirect target had bits[1:0] != 0
redirect_cnt  out  CNT_W  saturating count of applied redirects

Interface (already decided): one clock, CLK. Reset RST_N is asynchronous and active-low.

Behaviour:
- RST_N low (asynchronous) sets the following:
  - pc = RESET_VEC
  - state = BOOT
  - fetch_valid = 0
  - misalign_err = 0
  - redirect_cnt = 0
  - RST_N low mid-operation aborts any bundle or redirect in flight immediately; no partial update survives.
- States:
  - BOOT: exactly one cycle after reset release, fetch_valid = 0. Goes to RUN, or to HALTED if halt = 1.
  - RUN: fetch_valid = 1. Goes to HALTED when halt = 1 and no redirect is present.
  - HALTED: fetch_valid = 0. Goes to RUN when halt = 0.
- Redirect select: sel = lowest index k with redir_valid[k] = 1. Any redirect is always applied at the next edge, in every state except BOOT, regardless of fetch_ready or halt.
  - pc <= {redir_target[sel][WIDTH-1:2], 2'b00}.
  - A redirect in HALTED updates pc but stays HALTED if halt = 1.
  - Redirects presented during BOOT are ignored.
- misalign_err: registered. Equals 1 for exactly one cycle after an applied redirect whose selected target[1:0] != 0. Unselected sources are never checked.
- redirect_cnt: +1 per edge on which a redirect is applied, independent of how many sources are valid. Saturates at all-ones with no wrap.
- Fetch lanes (combinational from pc):
  - fetch_pc lane i = pc + 4*i, modulo 2^WIDTH.
  - off = pc[2 +: log2(FETCH_W)], with off = 0 when FETCH_W = 1.
  - fetch_mask[i] = (off + i < FETCH_W), so a bundle never crosses a FETCH_W*4-byte boundary.
  - fetch_mask is meaningful only when fetch_valid = 1 and is held stable when fetch_valid = 0.
- Advance: in RUN, with fetch_valid & fetch_ready and no redirect, pc <= pc + 4*(FETCH_W - off), i.e. the next aligned block. Wrap past 2^WIDTH is silent.
- Stall: fetch_valid = 1 and fetch_ready = 0 holds pc, fetch_pc and fetch_mask stable.
- Redirect concurrent with an accept: the bundle counts as consumed, but the redirect target wins for the next pc (no +advance). The consumer flushes the bundle.
- halt concurrent with an accept: the accept advances pc, then the block enters HALTED.
- Latency: redirect to new fetch_pc visible is 1 cycle. No combinational path from fetch_ready or redir_* to fetch_valid.

Test Plan:
1. FETCH_W=2, RESET_VEC=0. Release RST_N.
   - Required: fetch_valid=0 for 1 cycle, then fetch_pc={0x0,0x4}, mask=2'b11.
   - Then fetch_ready=1 for 2 cycles. Required: pc 0x0 -> 0x8 -> 0x10.
2. Redirect to 0x104.
   - Required next cycle: fetch_pc={0x104,0x108}, mask=2'b01.
   - Then accept. Required: pc=0x108, mask=2'b11. redirect_cnt=1.
3. fetch_ready=0 for 3 cycles at pc 0x20.
   - Required: fetch_pc/mask unchanged.
   - Then redirect 0x40 with fetch_ready=0. Required: pc=0x40 next cycle.
4. Same cycle: redir_valid=4'b0101, target[0]=0x200, target[2]=0x300.
   - Required: pc=0x200, redirect_cnt +1 only.
   - Then target[0]=0x202. Required: pc=0x200, misalign_err=1 for one cycle.
5. halt=1 during RUN with accept.
   - Required: pc advances once, then fetch_valid=0.
   - Redirect 0x80 while halted. Required: pc=0x80, fetch_valid stays 0.
   - halt=0. Required: fetch_valid=1 at 0x80.
6. Assert RST_N=0 mid-stall at pc 0x1C.
   - Required immediately: fetch_valid=0, pc=RESET_VEC, counters=0.
   - Also: with CNT_W=2, 5 redirects leave redirect_cnt=3.
